// File: rtl/hsv_stream_ctrl.sv
// Valid/ready sequencer around the fixed-latency rgb2hsv core.
// Tracks pixels in flight, buffers results in a FWFT FIFO, counts frames/lines.
module hsv_stream_ctrl #(
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [23:0]      s_data,
  input  logic             s_sof,
  input  logic             s_eol,
  output logic [23:0]      core_rgb,
  input  logic [23:0]      core_hsv,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [23:0]      m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] line_cnt
);

  localparam int TP = PIPE_LAT + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic             r_s_ready;
  logic [23:0]      r_rgb;
  logic [TP-1:0]    r_tv;
  logic [TP-1:0]    r_ts;
  logic [TP-1:0]    r_te;
  logic [CW-1:0]    r_occ;
  logic [25:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_frame;
  logic [CNT_W-1:0] r_line;

  logic             w_acc;
  logic             w_pop;
  logic             w_wr;
  logic             w_hsof;
  logic             w_heol;
  logic [CW-1:0]    w_occ_nxt;
  logic [25:0]      w_head;

  assign w_acc     = s_valid & r_s_ready;
  assign m_valid   = (r_cnt != '0);
  assign w_pop     = m_valid & m_ready;
  assign w_wr      = r_tv[TP-1];
  assign w_occ_nxt = r_occ + CW'(w_acc) - CW'(w_pop);
  assign w_head    = r_mem[r_rp];
  assign w_hsof    = w_head[1];
  assign w_heol    = w_head[0];

  assign s_ready   = r_s_ready;
  assign core_rgb  = r_rgb;
  assign m_data    = m_valid ? w_head[25:2] : 24'h0;
  assign m_sof     = m_valid & w_hsof;
  assign m_eol     = m_valid & w_heol;
  assign busy      = (r_occ != '0);
  assign frame_cnt = r_frame;
  assign line_cnt  = r_line;

  // Credits count core slots plus FIFO slots, so the
  // non-stallable core can never overrun the FIFO.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_s_ready <= 1'b0;
      r_rgb     <= 24'h0;
      r_tv      <= '0;
      r_ts      <= '0;
      r_te      <= '0;
      r_occ     <= '0;
    end else begin
      r_s_ready <= enable && (w_occ_nxt < FULL);
      r_rgb     <= w_acc ? s_data : 24'h0;
      r_tv      <= {r_tv[TP-2:0], w_acc};
      r_ts      <= {r_ts[TP-2:0], w_acc & s_sof};
      r_te      <= {r_te[TP-2:0], w_acc & s_eol};
      r_occ     <= w_occ_nxt;
      assert (r_occ <= FULL);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst_n && w_wr) begin
      r_mem[r_wp] <= {core_hsv, r_ts[TP-1], r_te[TP-1]};
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= (r_rp == LAST) ? '0 : r_rp + 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
      assert (!(w_wr && (r_cnt == FULL)));
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_line  <= '0;
    end else if (w_pop) begin
      if (w_hsof) begin
        r_frame <= r_frame + 1'b1;
        r_line  <= w_heol ? CNT_W'(1) : '0;
      end else if (w_heol) begin
        r_line  <= r_line + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hsv_stream_ctrl.sv
// Directed bench for hsv_stream_ctrl with a 2-cycle rgb2hsv stand-in.
// Inputs change and outputs are sampled on the falling edge.
module tb_hsv_stream_ctrl;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = 24'h0;
  logic        s_sof = 1'b0;
  logic        s_eol = 1'b0;
  logic [23:0] core_rgb;
  logic [23:0] core_hsv = 24'h0;
  logic [23:0] st1 = 24'h0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_eol;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] line_cnt;

  int checks = 0;
  int passed = 0;

  hsv_stream_ctrl #(
    .PIPE_LAT   (2),
    .FIFO_DEPTH (8),
    .CNT_W      (16)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_eol     (s_eol),
    .core_rgb  (core_rgb),
    .core_hsv  (core_hsv),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eol     (m_eol),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .line_cnt  (line_cnt)
  );

  always #5 pclk = ~pclk;

  function automatic logic [23:0] hsv(input logic [23:0] rgb);
    int r, g, b, mx, mn, d, h, s;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    d = mx - mn;
    s = (mx == 0) ? 0 : (d * 255) / mx;
    if (d == 0) h = 0;
    else if (mx == r) h = (30 * (g - b)) / d;
    else if (mx == g) h = 60 + (30 * (b - r)) / d;
    else h = 120 + (30 * (r - g)) / d;
    if (h < 0) h = h + 180;
    return {h[7:0], s[7:0], mx[7:0]};
  endfunction

  always_ff @(posedge pclk) begin
    st1      <= hsv(core_rgb);
    core_hsv <= st1;
  end

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b want 0", s_ready); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid); else passed++;
    checks++; if ({m_data, m_sof, m_eol} !== 26'h0) $display("FAIL rst_m_data got %h want 0", {m_data, m_sof, m_eol}); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    checks++; if (frame_cnt !== 16'h0) $display("FAIL rst_frame got %0d want 0", frame_cnt); else passed++;
    checks++; if (line_cnt !== 16'h0) $display("FAIL rst_line got %0d want 0", line_cnt); else passed++;
    checks++; if (core_rgb !== 24'h0) $display("FAIL rst_core_rgb got %h want 0", core_rgb); else passed++;
    rst_n = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) $display("FAIL post_rst_s_ready got %b want 1", s_ready); else passed++;
  endtask

  task automatic test_single();
    int cyc;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data = 24'hFF0000;
    s_sof = 1'b1;
    s_eol = 1'b0;
    checks++; if (s_ready !== 1'b1) $display("FAIL single_ready got %b want 1", s_ready); else passed++;
    tick();
    s_valid = 1'b0;
    s_sof = 1'b0;
    checks++; if (core_rgb !== 24'hFF0000) $display("FAIL single_core_rgb got %h want ff0000", core_rgb); else passed++;
    cyc = 0;
    while (!m_valid && cyc < 8) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 3) $display("FAIL single_latency got %0d want 3", cyc); else passed++;
    checks++; if (m_data !== 24'h00FFFF) $display("FAIL single_data got %h want 00ffff", m_data); else passed++;
    checks++; if ({m_sof, m_eol} !== 2'b10) $display("FAIL single_tags got %b want 10", {m_sof, m_eol}); else passed++;
    tick();
    checks++; if (frame_cnt !== 16'd1) $display("FAIL single_frame got %0d want 1", frame_cnt); else passed++;
    checks++; if (line_cnt !== 16'd0) $display("FAIL single_line got %0d want 0", line_cnt); else passed++;
    checks++; if ({m_valid, busy} !== 2'b00) $display("FAIL single_idle got %b want 00", {m_valid, busy}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] q[$];
    logic [23:0] exp;
    int tx, rx, stalls, cyc;
    tx = 0; rx = 0; stalls = 0; cyc = 0;
    m_ready = 1'b1;
    while ((tx < 16 || rx < 16) && cyc < 100) begin
      if (m_valid && m_ready) begin
        exp = (q.size() != 0) ? q.pop_front() : 24'hxxxxxx;
        checks++; if (m_data !== exp) $display("FAIL b2b_data[%0d] got %h want %h", rx, m_data, exp); else passed++;
        rx++;
      end
      if (tx < 16) begin
        s_valid = 1'b1;
        s_data = tx[0] ? 24'h00FF00 : 24'h808080;
        if (s_ready) begin
          q.push_back(tx[0] ? 24'h3CFFFF : 24'h000080);
          tx++;
        end else begin
          stalls++;
        end
      end else begin
        s_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (stalls != 0) $display("FAIL b2b_stalls got %0d want 0", stalls); else passed++;
    checks++; if (rx != 16) $display("FAIL b2b_count got %0d want 16", rx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_backpressure();
    logic [23:0] q[$];
    logic [23:0] exp;
    int acc, rx;
    bit seen;
    acc = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data = {8'((acc + 1) * 16), 16'h0};
      if (s_ready) begin
        q.push_back({8'h00, 8'hFF, 8'((acc + 1) * 16)});
        acc++;
      end
      tick();
    end
    s_valid = 1'b0;
    checks++; if (acc != 8) $display("FAIL bp_accepts got %0d want 8", acc); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", s_ready); else passed++;
    checks++; if ({m_valid, busy} !== 2'b11) $display("FAIL bp_full_state got %b want 11", {m_valid, busy}); else passed++;
    m_ready = 1'b1;
    checks++; if (s_ready !== 1'b0) $display("FAIL bp_release_ready got %b want 0", s_ready); else passed++;
    rx = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_valid) begin
        exp = (q.size() != 0) ? q.pop_front() : 24'hxxxxxx;
        checks++; if (m_data !== exp) $display("FAIL bp_data[%0d] got %h want %h", rx, m_data, exp); else passed++;
        rx++;
      end
      tick();
      if (rx == 1 && !seen) begin
        seen = 1'b1;
        checks++; if (s_ready !== 1'b1) $display("FAIL bp_credit_ready got %b want 1", s_ready); else passed++;
      end
    end
    checks++; if (rx != 8) $display("FAIL bp_pops got %0d want 8", rx); else passed++;
    checks++; if ({m_valid, busy} !== 2'b00) $display("FAIL bp_drained got %b want 00", {m_valid, busy}); else passed++;
  endtask

  task automatic test_tags();
    logic [25:0] q[$];
    logic [25:0] exp;
    int tx, rx, cyc;
    apply_reset();
    m_ready = 1'b1;
    tx = 0; rx = 0; cyc = 0;
    while ((tx < 24 || rx < 24) && cyc < 100) begin
      if (m_valid) begin
        exp = (q.size() != 0) ? q.pop_front() : 26'hxxxxxxx;
        checks++; if ({m_data, m_sof, m_eol} !== exp) $display("FAIL tags_px[%0d] got %h want %h", rx, {m_data, m_sof, m_eol}, exp); else passed++;
        rx++;
      end
      if (tx < 24) begin
        s_valid = 1'b1;
        s_data = {3{8'(tx + 1)}};
        s_sof = ((tx % 12) == 0);
        s_eol = ((tx % 4) == 3);
        if (s_ready) begin
          q.push_back({16'h0, 8'(tx + 1), s_sof, s_eol});
          tx++;
        end
      end else begin
        s_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_eol = 1'b0;
    checks++; if (rx != 24) $display("FAIL tags_count got %0d want 24", rx); else passed++;
    checks++; if (frame_cnt !== 16'd2) $display("FAIL tags_frame got %0d want 2", frame_cnt); else passed++;
    checks++; if (line_cnt !== 16'd3) $display("FAIL tags_line got %0d want 3", line_cnt); else passed++;
  endtask

  task automatic test_enable();
    logic [23:0] q[$];
    logic [23:0] exp;
    int rx;
    bit seen1, seen2;
    m_ready = 1'b1;
    enable = 1'b1;
    s_valid = 1'b1;
    s_data = 24'h0000FF;
    q.push_back(24'h78FFFF);
    tick();
    s_data = 24'h202020;
    q.push_back(24'h000020);
    tick();
    s_valid = 1'b0;
    enable = 1'b0;
    tick();
    checks++; if (s_ready !== 1'b0) $display("FAIL en_ready got %b want 0", s_ready); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL en_busy got %b want 1", busy); else passed++;
    s_valid = 1'b1;
    s_data = 24'hFFFFFF;
    rx = 0;
    seen1 = 1'b0;
    seen2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid) begin
        exp = (q.size() != 0) ? q.pop_front() : 24'hxxxxxx;
        checks++; if (m_data !== exp) $display("FAIL en_data[%0d] got %h want %h", rx, m_data, exp); else passed++;
        rx++;
      end
      tick();
      if (rx == 1 && !seen1) begin
        seen1 = 1'b1;
        checks++; if (busy !== 1'b1) $display("FAIL en_busy_mid got %b want 1", busy); else passed++;
      end
      if (rx == 2 && !seen2) begin
        seen2 = 1'b1;
        checks++; if (busy !== 1'b0) $display("FAIL en_busy_end got %b want 0", busy); else passed++;
      end
    end
    checks++; if (rx != 2) $display("FAIL en_pops got %0d want 2", rx); else passed++;
    s_valid = 1'b0;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int stale, cyc;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data = {8'h10, 8'(i * 40), 8'h90};
      tick();
    end
    s_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL rm_busy_pre got %b want 1", busy); else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({m_valid, busy} !== 2'b00) $display("FAIL rm_state got %b want 00", {m_valid, busy}); else passed++;
    checks++; if ({frame_cnt, line_cnt} !== 32'h0) $display("FAIL rm_counters got %h want 0", {frame_cnt, line_cnt}); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL rm_ready got %b want 0", s_ready); else passed++;
    m_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid) stale++;
      tick();
    end
    checks++; if (stale != 0) $display("FAIL rm_stale got %0d want 0", stale); else passed++;
    s_valid = 1'b1;
    s_data = 24'h00FF00;
    tick();
    s_valid = 1'b0;
    cyc = 0;
    while (!m_valid && cyc < 8) begin
      tick();
      cyc++;
    end
    checks++; if (m_data !== 24'h3CFFFF) $display("FAIL rm_fresh got %h want 3cffff", m_data); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL rm_idle got %b want 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_tags();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
